// File: rtl/config_pkg.sv
// Shared types and constants for the bitstream configuration loader.
// Holds the loader FSM encoding, bitstream magic, error codes and section ids.
package config_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_DATA,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] CFG_MAGIC = 16'hC0F1;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_SIZE  = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [15:0] SEC_CB0 = 16'd4;
  localparam logic [15:0] SEC_CB1 = 16'd5;
  localparam logic [15:0] SEC_SB  = 16'd6;
  localparam logic [15:0] SEC_CLB = 16'd7;

endpackage

// File: rtl/config_loader.sv
// Streams {addr,data} pairs from a bitstream RAM onto the tile config bus.
// CONFIG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word check.
module config_loader
  import config_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       config_addr,
  output logic [31:0]       config_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [15:0]       write_count
);

`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam logic [32:0] TAIL_W = 33'd1;
  localparam state_t      END_ST = S_CSUM;
`else
  localparam logic [32:0] TAIL_W = 33'd0;
  localparam state_t      END_ST = S_DONE;
`endif
  localparam logic [32:0] MEM_WORDS = 33'd1 << MEM_AW;
  localparam logic        END_RD    = (END_ST == S_CSUM);

  state_t              state_q;
  logic                phase_q;
  logic [MEM_AW-1:0]   ptr_q;
  logic [15:0]         n_q;
  logic [15:0]         wc_q;
  logic [31:0]         addr_q;
  logic [31:0]         cfga_q;
  logic [31:0]         cfgd_q;
  logic                mem_en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          code_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0]         xor_q;
`endif

  logic [32:0] need_d;
  logic        ovf_d;
  logic [15:0] wc_d;

  // header + 2N pair words (+ checksum) must fit in the RAM
  assign need_d = {16'd0, mem_rdata[15:0], 1'b1} + TAIL_W;
  assign ovf_d  = need_d > MEM_WORDS;
  assign wc_d   = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      ptr_q    <= '0;
      n_q      <= '0;
      wc_q     <= '0;
      addr_q   <= '0;
      cfga_q   <= '0;
      cfgd_q   <= '0;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      cfga_q   <= '0;
      cfgd_q   <= '0;
      mem_en_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        phase_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        code_q  <= ERR_NONE;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state_q  <= S_HDR;
              phase_q  <= 1'b0;
              mem_en_q <= 1'b1;
              ptr_q    <= '0;
              wc_q     <= '0;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              code_q   <= ERR_NONE;
            end
          end
          S_HDR: begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              ptr_q   <= ptr_q + 1'b1;
              n_q     <= mem_rdata[15:0];
`ifdef CONFIG_LOADER_CHECKSUM_EN
              xor_q   <= mem_rdata;
`endif
              if (mem_rdata[31:16] != CFG_MAGIC) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                code_q  <= ERR_MAGIC;
              end else if (ovf_d) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                code_q  <= ERR_SIZE;
              end else if (mem_rdata[15:0] == 16'd0) begin
                state_q  <= END_ST;
                mem_en_q <= END_RD;
                busy_q   <= END_RD;
                done_q   <= !END_RD;
              end else begin
                state_q  <= S_ADDR;
                mem_en_q <= 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q  <= 1'b0;
              ptr_q    <= ptr_q + 1'b1;
              addr_q   <= mem_rdata;
`ifdef CONFIG_LOADER_CHECKSUM_EN
              xor_q    <= xor_q ^ mem_rdata;
`endif
              state_q  <= S_DATA;
              mem_en_q <= 1'b1;
            end
          end
          S_DATA: begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              ptr_q   <= ptr_q + 1'b1;
              cfga_q  <= addr_q;
              cfgd_q  <= mem_rdata;
              wc_q    <= wc_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
              xor_q   <= xor_q ^ mem_rdata;
`endif
              state_q <= S_WR;
            end
          end
          S_WR: begin
            // count already includes this write
            if (wc_q < n_q) begin
              state_q  <= S_ADDR;
              mem_en_q <= 1'b1;
            end else begin
              state_q  <= END_ST;
              mem_en_q <= END_RD;
              busy_q   <= END_RD;
              done_q   <= !END_RD;
            end
          end
`ifdef CONFIG_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              ptr_q   <= ptr_q + 1'b1;
              busy_q  <= 1'b0;
              if (mem_rdata != xor_q) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                code_q  <= ERR_CSUM;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
`endif
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = ptr_q;
  assign config_addr = cfga_q;
  assign config_data = cfgd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign error_code  = code_q;
  assign write_count = wc_q;

endmodule
